// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the M-stage data-memory
//               responder: FSM state encoding, word size and the byte-offset
//               mask used to detect misaligned word accesses.
// Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

    // Responder FSM states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam int         WORD_BYTES    = 4;
    localparam logic [1:0] MISALIGN_MASK = 2'b11;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/dmem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ram
// Description : Single-port word RAM with synchronous write and registered
//               read. The array has no reset; the read register only
//               updates when i_re is high, so it holds between reads.
// Ports       : clk      - clock
//               i_we     - write enable (writes i_wdata at i_addr)
//               i_re     - read enable (captures RAM[i_addr] into o_rdata)
//               i_addr   - word index
//               i_wdata  - write data
//               o_rdata  - registered read data
// Revision    : 1.0  initial release
// ============================================================================
module dmem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : dmem_ram
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : M-stage data-memory responder. Accepts a word load/store,
//               waits WAIT_CYCLES extra cycles, performs the access on the
//               internal RAM and pulses o_mem_ready for one cycle. o_stall
//               holds the pipeline until the completion cycle.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_mem_req     - request valid (held while o_stall=1)
//               i_mem_we      - 1 = store, 0 = load
//               i_mem_addr    - byte address
//               i_mem_wdata   - store data
//               o_mem_rdata   - load data, valid with o_mem_ready
//               o_mem_ready   - one-cycle completion pulse
//               o_stall       - pipeline stall toward hazard unit
//               o_misalign    - completing access had addr[1:0] != 0
// Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_ready,
    output logic        o_stall,
    output logic        o_misalign
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int OFF_W  = $clog2(WORD_BYTES);
    localparam int CNT_W  = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    // Elaboration-time parameter checks.
    if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "dmem_responder: DEPTH_WORDS must be a power of 2 and >= 2");
    end
    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_wait
        $fatal(1, "dmem_responder: WAIT_CYCLES must be in 0..15");
    end

    dmem_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_idx;
    logic [OFF_W-1:0]  r_off;
    logic [31:0]       r_wdata;
    logic              r_from_ram;
    logic              r_misalign;

    logic              w_access;
    logic              w_aligned;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [31:0]       w_ram_rdata;
    // Upper address bits are deliberately ignored (addresses wrap).
    logic [31:0]       w_unused_addr;

    assign w_unused_addr = i_mem_addr;

    // The access happens on the edge that leaves BUSY with the counter at 0,
    // provided the request was not withdrawn (flush) in this cycle.
    assign w_access  = (r_state == BUSY) && i_mem_req && (r_cnt == '0);
    assign w_aligned = ((r_off & MISALIGN_MASK) == '0);
    assign w_ram_we  = w_access &  r_we & w_aligned;
    assign w_ram_re  = w_access & ~r_we & w_aligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_from_ram <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_mem_req) begin
                        r_we    <= i_mem_we;
                        r_idx   <= i_mem_addr[ADDR_W+OFF_W-1:OFF_W];
                        r_off   <= i_mem_addr[OFF_W-1:0];
                        r_wdata <= i_mem_wdata;
                        r_cnt   <= CNT_LOAD;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!i_mem_req) begin
                        r_state <= IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // Only an aligned load exposes RAM data; stores and
                        // misaligned accesses present zero.
                        r_from_ram <= ~r_we & w_aligned;
                        r_misalign <= ~w_aligned;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    // The request still visible here is the one just served.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // The RAM read register only changes on an aligned load, so this mux
    // holds the last completed result until the next completion.
    assign o_mem_rdata = r_from_ram ? w_ram_rdata : 32'h0;
    assign o_mem_ready = (r_state == DONE);
    assign o_stall     = i_mem_req & (r_state != DONE);
    assign o_misalign  = r_misalign;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder. Two instances:
//               dut0 with WAIT_CYCLES=2, dut1 with WAIT_CYCLES=0. Expected
//               completions are queued at issue time and popped by a monitor
//               on every o_mem_ready pulse.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        stall [2];
    logic        mis   [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .i_mem_req   (req[0]),
        .i_mem_we    (we[0]),
        .i_mem_addr  (addr[0]),
        .i_mem_wdata (wdata[0]),
        .o_mem_rdata (rdata[0]),
        .o_mem_ready (ready[0]),
        .o_stall     (stall[0]),
        .o_misalign  (mis[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .i_mem_req   (req[1]),
        .i_mem_we    (we[1]),
        .i_mem_addr  (addr[1]),
        .i_mem_wdata (wdata[1]),
        .o_mem_rdata (rdata[1]),
        .o_mem_ready (ready[1]),
        .o_stall     (stall[1]),
        .o_misalign  (mis[1])
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   nchecks = 0;
    int   nerr    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ready[d] === 1'b1) begin
                exp_t e;
                if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                    nchecks++;
                    nerr++;
                    $display("FAIL unexpected_ready dut%0d: got ready=1 expected no completion", d);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("rdata_dut%0d", d), rdata[d], e.rdata);
                    check($sformatf("misalign_dut%0d", d), {31'b0, mis[d]}, {31'b0, e.mis});
                end
            end
        end
    end

    // Issue one request, queue its expected result and check latency/stall.
    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] er,
                          input logic em, input int lat);
        exp_t e;
        int   n;
        logic stall_ok;
        @(posedge clk); #1;
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        e.rdata  = er;
        e.mis    = em;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        n        = 0;
        stall_ok = 1'b1;
        while (1) begin
            @(negedge clk);
            if (ready[d] === 1'b1) break;
            if (stall[d] !== 1'b1) stall_ok = 1'b0;
            n++;
            if (n > 30) break;
        end
        check($sformatf("latency_dut%0d_a%0h", d, a), 32'(n), 32'(lat));
        check($sformatf("stall_busy_dut%0d_a%0h", d, a), {31'b0, stall_ok}, 32'd1);
        check($sformatf("stall_done_dut%0d_a%0h", d, a), {31'b0, stall[d]}, 32'd0);
    endtask

    task automatic release_req(input int d);
        @(posedge clk); #1;
        req[d] = 1'b0;
    endtask

    task automatic check_quiet(input string name, input int d, input logic [31:0] er);
        check({name, "_rdata"}, rdata[d], er);
        check({name, "_ready"}, {31'b0, ready[d]}, 32'd0);
        check({name, "_stall"}, {31'b0, stall[d]}, 32'd0);
        check({name, "_mis"},   {31'b0, mis[d]},   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0;
        end

        // Reset then idle.
        repeat (2) begin
            @(negedge clk);
            check_quiet("reset_dut0", 0, 32'h0);
            check_quiet("reset_dut1", 1, 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_quiet("idle_dut0", 0, 32'h0);
        end

        // Store then load, same word.
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 4);
        access(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4);
        release_req(0);
        @(negedge clk);
        check_quiet("hold_after_done", 0, 32'hDEADBEEF);

        // Address wrap modulo 1 KiB.
        access(0, 1'b1, 32'h400, 32'h12345678, 32'h0, 1'b0, 4);
        access(0, 1'b0, 32'h000, 32'h0, 32'h12345678, 1'b0, 4);

        // Misaligned store must not disturb word 8.
        access(0, 1'b1, 32'h20, 32'h0BADF00D, 32'h0, 1'b0, 4);
        access(0, 1'b1, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b1, 4);
        access(0, 1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, 4);

        // Flush mid-access: request dropped in cycle 2.
        access(0, 1'b1, 32'h30, 32'h11112222, 32'h0, 1'b0, 4);
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hA5A5A5A5;
        @(posedge clk);
        @(posedge clk); #1;
        req[0] = 1'b0;
        ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (stall[0] !== 1'b0 || ready[0] !== 1'b0) ok = 1'b0;
        end
        check("flush_quiet", {31'b0, ok}, 32'd1);
        access(0, 1'b0, 32'h30, 32'h0, 32'h11112222, 1'b0, 4);

        // Reset in cycle 1 of a store abandons it.
        access(0, 1'b1, 32'h40, 32'h01010101, 32'h0, 1'b0, 4);
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'hFEFEFEFE;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        check_quiet("after_mid_reset", 0, 32'h0);
        access(0, 1'b0, 32'h40, 32'h0, 32'h01010101, 1'b0, 4);
        release_req(0);

        // Zero wait states: 2-cycle latency.
        access(1, 1'b1, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0, 2);
        access(1, 1'b0, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0, 2);
        release_req(1);

        repeat (4) @(negedge clk);
        check("pending_dut0", 32'(q0.size()), 32'd0);
        check("pending_dut1", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the memory (M) stage of the pipelined core. It accepts word load/store requests, serves them from an internal word-addressed RAM after a configurable number of wait states, and raises a stall toward the hazard unit until the access completes. It sits between the M-stage address/write-data/write-enable outputs and the M-stage read-data input.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the RAM; must be a power of 2, at least 2.
WAIT_CYCLES, 2, extra BUSY cycles before each access completes; range 0..15.
ADDR_W, $clog2(DEPTH_WORDS), word-index width; derived, not overridden.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
i_mem_req  input  1  M stage holds a valid load or store; held stable while o_stall=1
i_mem_we  input  1  1 = store, 0 = load; sampled with i_mem_req
i_mem_addr  input  32  byte address (ALUResultM)
i_mem_wdata  input  32  store data (WriteDataM)
o_mem_rdata  output  32  load data (to ReadDataM); valid while o_mem_ready=1
o_mem_ready  output  1  one-cycle completion pulse
o_stall  output  1  to hazard unit; freezes F/D/E/M and bubbles W
o_misalign  output  1  addr[1:0]!=0 on the completing access; valid with o_mem_ready

Behaviour:
- Reset, synchronous on rst=1: state=IDLE, wait counter=0, o_mem_rdata=0, o_mem_ready=0, o_misalign=0. RAM contents are not cleared. Reset during BUSY abandons the access and performs no write.
- FSM has three states: IDLE, BUSY, DONE.
  - IDLE: if i_mem_req=1, latch we/addr/wdata, load counter with WAIT_CYCLES, go to BUSY. Otherwise stay in IDLE.
  - BUSY: if i_mem_req=0 (flush), go to IDLE, no write, rdata unchanged. Else if counter!=0, decrement. Else perform the access at this edge and go to DONE.
  - DONE: o_mem_ready=1 for exactly this cycle. Always return to IDLE; the still-asserted req in this cycle is the same request and is not re-accepted.
- Latency: request first presented in cycle 0 gives o_mem_ready in cycle WAIT_CYCLES+2. Minimum is 2 cycles, at WAIT_CYCLES=0.
- o_stall is combinational: i_mem_req & (state!=DONE). It is high in cycles 0..WAIT_CYCLES+1 and low in DONE so the pipeline advances.
- Access rules:
  - Word index = latched addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Aligned store: RAM[idx] <= wdata; o_mem_rdata <= 0.
  - Aligned load: o_mem_rdata <= RAM[idx].
  - Misaligned (addr[1:0]!=0): no RAM write, o_mem_rdata <= 0, o_misalign=1 in DONE.
- o_mem_rdata holds its value after DONE until the next completing access.
- Store followed by load to the same word: the load returns the new data. Accesses are serialized, so no bypass is needed.
- Throughput: at most one access per WAIT_CYCLES+3 cycles, counting the IDLE re-accept cycle.
- Counter width: max(1, $clog2(WAIT_CYCLES+1)).
- Elaboration-time assertion fails if DEPTH_WORDS is not a power of 2 or WAIT_CYCLES>15.

Decomposition:
- Shared package (mem_pkg):
  - state enum dmem_state_t {IDLE, BUSY, DONE}.
  - constants WORD_BYTES=4 and MISALIGN_MASK=2'b11.
- One sub-module, dmem_ram: single-port synchronous-write, registered-read word RAM parameterised by DEPTH_WORDS, with no reset on the array. The FSM, counter and stall logic stay in dmem_responder.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no req -> rdata=0, ready=0, stall=0, misalign=0 throughout.
- Store then load, WAIT_CYCLES=2:
  - Store: req, we=1, addr=0x10, wdata=0xDEADBEEF in cycle 0 -> stall high cycles 0-3, ready only in cycle 4.
  - Load: req, we=0, addr=0x10 presented in cycle 5 -> rdata=0xDEADBEEF in cycle 9.
- Wrap-around, DEPTH_WORDS=256: store 0x12345678 to addr 0x400, then load addr 0x000 -> rdata=0x12345678.
- Misaligned: store to addr 0x22 with wdata=0xFFFFFFFF, then load aligned 0x20 -> first completion misalign=1, rdata=0; second returns the prior contents of word 8, unchanged.
- Flush mid-access: store addr 0x30, wdata=0xA5A5A5A5; drop req in cycle 2 -> FSM returns to IDLE, no ready pulse; a later load of 0x30 returns the old value.
- Reset mid-BUSY and WAIT_CYCLES=0:
  - rst in cycle 1 of a store -> no write.
  - With WAIT_CYCLES=0, a load presented in cycle 0 -> ready in cycle 2, stall high for cycles 0-1 only.
